// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Orders reset release across the FPGA reset domains once the PLL is locked.
//   It first waits for the synchronized lock to stay high for LOCK_WAIT cycles.
//   It then releases the per-domain active-low resets one stage at a time,
//   STAGE_GAP cycles apart, with stage 0 first.
//   A software warm reset holds every stage low for SOFT_HOLD cycles. The
//   stages are then re-released without repeating the lock wait, and the
//   request is acknowledged with a one-cycle pulse.
//   Losing lock after sequencing has started drops every stage immediately and
//   sets a sticky flag.
//
// Ports
//   clk_24MHz     sole clock
//   rst_n         asynchronous active-low reset, clears all state
//   pll_locked    PLL lock, asynchronous, synchronized internally (2 flops)
//   soft_rst_req  warm reset request, honoured only while in RUN
//   lock_lost_clr clears the sticky lock_lost flag
//   rst_n_stage   per-domain active-low resets (registered)
//   seq_done      high while every stage is released (RUN)
//   soft_rst_ack  one-cycle pulse when a warm reset completes
//   lock_lost     sticky: lock dropped after sequencing had started
//   seq_state     current FSM state code, for debug
module reset_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int LOCK_WAIT  = 240,
  parameter int STAGE_GAP  = 24,
  parameter int SOFT_HOLD  = 48,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_24MHz,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  input  logic                  lock_lost_clr,
  output logic [NUM_STAGES-1:0] rst_n_stage,
  output logic                  seq_done,
  output logic                  soft_rst_ack,
  output logic                  lock_lost,
  output logic [2:0]            seq_state
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SOFT_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT_HOLD = 3'd4
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             soft_pending;
  logic             sequencing;

  assign seq_state  = state;
  // Lock loss counts only once stages are being released or already held.
  assign sequencing = (state == ST_RELEASE) || (state == ST_RUN) ||
                      (state == ST_SOFT_HOLD);

  // Two-flop synchronizer. pll_locked is asynchronous to clk_24MHz.
  always_ff @(posedge clk_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Sequencer FSM. The counter is shared between the lock wait, the stage gap
  // and the soft-reset hold, because only one of them is active at a time.
  // Lock loss is checked before anything else, so it beats a soft request or
  // counter expiry that happens in the same cycle. The sticky-flag clear is
  // written first so that a set in the same cycle overrides it.
  always_ff @(posedge clk_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_WAIT_LOCK;
      cnt          <= '0;
      idx          <= '0;
      soft_pending <= 1'b0;
      rst_n_stage  <= '0;
      seq_done     <= 1'b0;
      soft_rst_ack <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      soft_rst_ack <= 1'b0;
      if (lock_lost_clr) lock_lost <= 1'b0;

      if (sequencing && !lock_s) begin
        state        <= ST_WAIT_LOCK;
        cnt          <= '0;
        idx          <= '0;
        soft_pending <= 1'b0;
        rst_n_stage  <= '0;
        seq_done     <= 1'b0;
        lock_lost    <= 1'b1;
      end else begin
        case (state)
          ST_WAIT_LOCK: begin
            rst_n_stage <= '0;
            seq_done    <= 1'b0;
            cnt         <= '0;
            if (lock_s) state <= ST_STABLE;
          end

          ST_STABLE: begin
            if (!lock_s) begin
              state <= ST_WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == LOCK_LAST) begin
              state <= ST_RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          // The last stage, seq_done and a pending ack all appear on the same
          // edge, so the ack lines up with the first seq_done cycle.
          ST_RELEASE: begin
            if (cnt == GAP_LAST) begin
              rst_n_stage[idx] <= 1'b1;
              cnt              <= '0;
              idx              <= idx + IDX_W'(1);
              if (idx == IDX_LAST) begin
                state        <= ST_RUN;
                seq_done     <= 1'b1;
                idx          <= '0;
                soft_rst_ack <= soft_pending;
                soft_pending <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_RUN: begin
            rst_n_stage <= '1;
            seq_done    <= 1'b1;
            if (soft_rst_req) begin
              state        <= ST_SOFT_HOLD;
              rst_n_stage  <= '0;
              seq_done     <= 1'b0;
              cnt          <= '0;
              soft_pending <= 1'b1;
            end
          end

          // Lock is already proven here, so the warm reset goes straight back
          // to releasing the stages.
          ST_SOFT_HOLD: begin
            if (cnt == HOLD_LAST) begin
              state <= ST_RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          default: begin
            state        <= ST_WAIT_LOCK;
            cnt          <= '0;
            idx          <= '0;
            soft_pending <= 1'b0;
            rst_n_stage  <= '0;
            seq_done     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer with NUM_STAGES=3, LOCK_WAIT=8,
//   STAGE_GAP=4 and SOFT_HOLD=6. Expected edge numbers are worked out by hand
//   from the cold-start rule: stage k rises 3 + LOCK_WAIT + (k+1)*STAGE_GAP
//   edges after pll_locked rises just after an edge.
module tb_reset_sequencer;

  logic       clk_24MHz = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       lock_lost_clr = 1'b0;
  logic [2:0] rst_n_stage;
  logic       seq_done;
  logic       soft_rst_ack;
  logic       lock_lost;
  logic [2:0] seq_state;

  int checkCount = 0;
  int failCount  = 0;
  int ackCount   = 0;

  reset_sequencer #(
    .NUM_STAGES(3),
    .LOCK_WAIT (8),
    .STAGE_GAP (4),
    .SOFT_HOLD (6),
    .CNT_W     (16)
  ) dut (
    .clk_24MHz    (clk_24MHz),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .lock_lost_clr(lock_lost_clr),
    .rst_n_stage  (rst_n_stage),
    .seq_done     (seq_done),
    .soft_rst_ack (soft_rst_ack),
    .lock_lost    (lock_lost),
    .seq_state    (seq_state)
  );

  always #5 clk_24MHz = ~clk_24MHz;

  // Count every ack pulse, sampled mid-cycle, so stray acks are caught.
  always @(negedge clk_24MHz) begin
    if (soft_rst_ack) ackCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_24MHz);
    #1;
  endtask

  // Cold sequence starting just after edge E0 from WAIT_LOCK with lock_s low.
  // When poke is set, a one-cycle soft request is issued during STABLE.
  task automatic applyStimulus(input string tag, input bit poke);
    pll_locked = 1'b1;
    tick(4);
    checkOutput({tag, ".stable_e4"}, 32'(seq_state), 32'd1);
    soft_rst_req = poke;
    tick(1);
    soft_rst_req = 1'b0;
    tick(9);
    checkOutput({tag, ".stage_e14"}, 32'(rst_n_stage), 32'b000);
    checkOutput({tag, ".state_e14"}, 32'(seq_state), 32'd2);
    tick(1);
    checkOutput({tag, ".stage_e15"}, 32'(rst_n_stage), 32'b001);
    tick(4);
    checkOutput({tag, ".stage_e19"}, 32'(rst_n_stage), 32'b011);
    tick(3);
    checkOutput({tag, ".done_e22"}, 32'(seq_done), 32'd0);
    tick(1);
    checkOutput({tag, ".stage_e23"}, 32'(rst_n_stage), 32'b111);
    checkOutput({tag, ".done_e23"}, 32'(seq_done), 32'd1);
    checkOutput({tag, ".state_e23"}, 32'(seq_state), 32'd3);
  endtask

  initial begin
    // Reset values
    #2 rst_n = 1'b0;
    tick(2);
    checkOutput("reset.stage", 32'(rst_n_stage), 32'd0);
    checkOutput("reset.done", 32'(seq_done), 32'd0);
    checkOutput("reset.ack", 32'(soft_rst_ack), 32'd0);
    checkOutput("reset.lost", 32'(lock_lost), 32'd0);
    checkOutput("reset.state", 32'(seq_state), 32'd0);

    // Cold start
    rst_n = 1'b1;
    tick(1);
    applyStimulus("cold", 1'b0);
    checkOutput("cold.ackcount", 32'(ackCount), 32'd0);

    // Soft reset from RUN, request sampled at edge T
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    checkOutput("soft.stage_t", 32'(rst_n_stage), 32'b000);
    checkOutput("soft.done_t", 32'(seq_done), 32'd0);
    checkOutput("soft.state_t", 32'(seq_state), 32'd4);
    tick(5);
    checkOutput("soft.state_t5", 32'(seq_state), 32'd4);
    tick(1);
    checkOutput("soft.state_t6", 32'(seq_state), 32'd2);
    tick(4);
    checkOutput("soft.stage_t10", 32'(rst_n_stage), 32'b001);
    tick(4);
    checkOutput("soft.stage_t14", 32'(rst_n_stage), 32'b011);
    tick(3);
    checkOutput("soft.done_t17", 32'(seq_done), 32'd0);
    checkOutput("soft.ack_t17", 32'(soft_rst_ack), 32'd0);
    tick(1);
    checkOutput("soft.stage_t18", 32'(rst_n_stage), 32'b111);
    checkOutput("soft.done_t18", 32'(seq_done), 32'd1);
    checkOutput("soft.ack_t18", 32'(soft_rst_ack), 32'd1);
    tick(1);
    checkOutput("soft.ack_t19", 32'(soft_rst_ack), 32'd0);
    checkOutput("soft.state_t19", 32'(seq_state), 32'd3);
    checkOutput("soft.ackcount", 32'(ackCount), 32'd1);

    // Lock loss and soft request reach the FSM on the same edge (D+3);
    // the clear is also asserted on that edge, and the set must win.
    pll_locked = 1'b0;
    tick(2);
    checkOutput("simul.state_d2", 32'(seq_state), 32'd3);
    soft_rst_req  = 1'b1;
    lock_lost_clr = 1'b1;
    tick(1);
    lock_lost_clr = 1'b0;
    checkOutput("simul.state_d3", 32'(seq_state), 32'd0);
    checkOutput("simul.stage_d3", 32'(rst_n_stage), 32'b000);
    checkOutput("simul.done_d3", 32'(seq_done), 32'd0);
    checkOutput("simul.lost_setwins", 32'(lock_lost), 32'd1);
    tick(2);
    soft_rst_req = 1'b0;
    checkOutput("simul.state_d5", 32'(seq_state), 32'd0);
    lock_lost_clr = 1'b1;
    tick(1);
    lock_lost_clr = 1'b0;
    checkOutput("simul.lost_cleared", 32'(lock_lost), 32'd0);
    checkOutput("simul.ackcount", 32'(ackCount), 32'd1);

    // Lock glitch: high 5 cycles, low 2, high again at R = G+7
    pll_locked = 1'b1;
    tick(3);
    checkOutput("glitch.state_g3", 32'(seq_state), 32'd1);
    tick(2);
    pll_locked = 1'b0;
    tick(2);
    checkOutput("glitch.state_g7", 32'(seq_state), 32'd1);
    pll_locked = 1'b1;
    tick(1);
    checkOutput("glitch.state_r1", 32'(seq_state), 32'd0);
    checkOutput("glitch.lost_r1", 32'(lock_lost), 32'd0);
    tick(2);
    checkOutput("glitch.state_r3", 32'(seq_state), 32'd1);
    tick(11);
    checkOutput("glitch.stage_r14", 32'(rst_n_stage), 32'b000);
    checkOutput("glitch.lost_r14", 32'(lock_lost), 32'd0);
    tick(1);
    checkOutput("glitch.stage_r15", 32'(rst_n_stage), 32'b001);

    // Lock loss mid-RELEASE right after stage 0 rose
    pll_locked = 1'b0;
    tick(2);
    checkOutput("midrel.stage_d2", 32'(rst_n_stage), 32'b001);
    checkOutput("midrel.state_d2", 32'(seq_state), 32'd2);
    tick(1);
    checkOutput("midrel.stage_d3", 32'(rst_n_stage), 32'b000);
    checkOutput("midrel.lost_d3", 32'(lock_lost), 32'd1);
    checkOutput("midrel.state_d3", 32'(seq_state), 32'd0);
    tick(3);

    // Lock returns: full cold sequence, with a soft request during STABLE
    applyStimulus("stablereq", 1'b1);
    tick(1);
    checkOutput("stablereq.state_run", 32'(seq_state), 32'd3);
    checkOutput("stablereq.ackcount", 32'(ackCount), 32'd1);

    // Async reset in the middle of SOFT_HOLD, between edges
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    checkOutput("async.state_hold", 32'(seq_state), 32'd4);
    tick(2);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async.state", 32'(seq_state), 32'd0);
    checkOutput("async.stage", 32'(rst_n_stage), 32'b000);
    checkOutput("async.done", 32'(seq_done), 32'd0);
    checkOutput("async.ack", 32'(soft_rst_ack), 32'd0);
    checkOutput("async.lost", 32'(lock_lost), 32'd0);
    pll_locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    applyStimulus("recold", 1'b0);
    checkOutput("recold.ackcount", 32'(ackCount), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
